// File: rtl/deser_pkg.sv
// Shared definitions for the serial-to-parallel comma aligner.
package deser_pkg;

    // Alignment FSM state encoding.
    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Default alignment K-character (K28.5-style comma byte).
    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;

endpackage

// File: rtl/deser_shift.sv
// Dual shift register for serial data and control-flag bits.
// Exposes the shift-next values so the aligner can act on the word that
// completes at the current edge without an extra cycle of latency.
module deser_shift #(
    parameter int BITS      = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            data,
    input  logic            dk,
    output logic [BITS-1:0] data_nxt,
    output logic [BITS-1:0] dk_nxt
);

    logic [BITS-1:0] data_sr;
    logic [BITS-1:0] dk_sr;

    // Shift direction decides where the first serial bit ends up.
    generate
        if (MSB_FIRST != 0) begin : g_msb_first
            assign data_nxt = {data_sr[BITS-2:0], data};
            assign dk_nxt   = {dk_sr[BITS-2:0], dk};
        end else begin : g_lsb_first
            assign data_nxt = {data, data_sr[BITS-1:1]};
            assign dk_nxt   = {dk, dk_sr[BITS-1:1]};
        end
    endgenerate

    // Shift both registers every edge; reset flushes any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_sr <= '0;
            dk_sr   <= '0;
        end else begin
            data_sr <= data_nxt;
            dk_sr   <= dk_nxt;
        end
    end

endmodule

// File: rtl/deser_align.sv
// Serial deserializer with comma-based word alignment.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HUNT   | searching every bit position for a full comma (all DK set)
// LOCKED | word boundary known; emit a word every BITS cycles, count
//        | misaligned commas and fall back to HUNT after LOSS of them
module deser_align
    import deser_pkg::*;
#(
    parameter int              BITS      = 8,
    parameter logic [BITS-1:0] COMMA     = BITS'(COMMA_DEFAULT),
    parameter int              LOSS      = 3,
    parameter int              MSB_FIRST = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            data,
    input  logic            DK,
    output logic [BITS-1:0] out,
    output logic [BITS-1:0] out_DK,
    output logic            valid,
    output logic            k_word,
    output logic            locked
);

    localparam int CNT_W  = $clog2(BITS);
    localparam int MISS_W = $clog2(LOSS + 1);

    localparam logic [CNT_W-1:0]  LAST_BIT   = CNT_W'(BITS - 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOSS);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [BITS-1:0]   out_d, out_dk_d;
    logic              valid_d, k_word_d;

    logic [BITS-1:0]   data_nxt, dk_nxt;
    logic              match;

    deser_shift #(
        .BITS      (BITS),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .reset    (reset),
        .data     (data),
        .dk       (DK),
        .data_nxt (data_nxt),
        .dk_nxt   (dk_nxt)
    );

    // A comma only counts when every bit of the window is flagged as control.
    assign match  = (data_nxt == COMMA) && (&dk_nxt);
    assign locked = (state_q == LOCKED);

    // State, counters and output word registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= HUNT;
            bit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            out        <= '0;
            out_DK     <= '0;
            valid      <= 1'b0;
            k_word     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            out        <= out_d;
            out_DK     <= out_dk_d;
            valid      <= valid_d;
            k_word     <= k_word_d;
        end
    end

    // Next-state, counter and word-capture decisions.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        out_d      = out;
        out_dk_d   = out_DK;
        valid_d    = 1'b0;
        k_word_d   = 1'b0;

        case (state_q)
            HUNT: begin
                if (match) begin
                    state_d    = LOCKED;
                    out_d      = data_nxt;
                    out_dk_d   = dk_nxt;
                    valid_d    = 1'b1;
                    k_word_d   = 1'b1;
                    bit_cnt_d  = '0;
                    miss_cnt_d = '0;
                end
            end

            LOCKED: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    out_d     = data_nxt;
                    out_dk_d  = dk_nxt;
                    valid_d   = 1'b1;
                    k_word_d  = &dk_nxt;
                    if (match) begin
                        miss_cnt_d = '0;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    // A comma off the boundary hints at slipped alignment.
                    if (match) begin
                        if (miss_cnt_q + MISS_W'(1) == MISS_LIMIT) begin
                            state_d    = HUNT;
                            bit_cnt_d  = '0;
                            miss_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_W'(1);
                        end
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

endmodule

// File: tb/tb_deser_align.sv
// Self-checking bench for deser_align: one MSB-first and one LSB-first instance.
module tb_deser_align;
    import deser_pkg::*;

    localparam int         BITS  = 8;
    localparam logic [7:0] COMMA = 8'hBC;

    typedef struct packed {
        logic [7:0] d;
        logic [7:0] k;
        logic       kw;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       data_m = 1'b0, dk_m = 1'b0;
    logic       data_l = 1'b0, dk_l = 1'b0;
    logic [7:0] out_m, out_dk_m, out_l, out_dk_l;
    logic       valid_m, kw_m, locked_m;
    logic       valid_l, kw_l, locked_l;

    exp_t q_m[$];
    exp_t q_l[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   t_lock = 0;

    deser_align #(.BITS(8), .COMMA(8'hBC), .LOSS(3), .MSB_FIRST(1)) dut (
        .clk(clk), .reset(reset), .data(data_m), .DK(dk_m),
        .out(out_m), .out_DK(out_dk_m), .valid(valid_m), .k_word(kw_m), .locked(locked_m)
    );

    deser_align #(.BITS(8), .COMMA(8'hBC), .LOSS(3), .MSB_FIRST(0)) dut_l (
        .clk(clk), .reset(reset), .data(data_l), .DK(dk_l),
        .out(out_l), .out_DK(out_dk_l), .valid(valid_l), .k_word(kw_l), .locked(locked_l)
    );

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of run, required finish before 200000");
        $fatal(1, "timeout");
    end

    // Scoreboard: every valid word pops the oldest expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                checks++;
                if (valid_m) begin
                    if (q_m.size() == 0) begin
                        failures++;
                        $display("FAIL msb_word: got unexpected word %h/%h k=%b, required none", out_m, out_dk_m, kw_m);
                    end else begin
                        e = q_m.pop_front();
                        if (out_m !== e.d || out_dk_m !== e.k || kw_m !== e.kw) begin
                            failures++;
                            $display("FAIL msb_word: got %h/%h k=%b, required %h/%h k=%b", out_m, out_dk_m, kw_m, e.d, e.k, e.kw);
                        end
                    end
                end else if (kw_m !== 1'b0) begin
                    failures++;
                    $display("FAIL msb_kword_idle: got k_word=%b, required 0", kw_m);
                end
                checks++;
                if (valid_l) begin
                    if (q_l.size() == 0) begin
                        failures++;
                        $display("FAIL lsb_word: got unexpected word %h/%h k=%b, required none", out_l, out_dk_l, kw_l);
                    end else begin
                        e = q_l.pop_front();
                        if (out_l !== e.d || out_dk_l !== e.k || kw_l !== e.kw) begin
                            failures++;
                            $display("FAIL lsb_word: got %h/%h k=%b, required %h/%h k=%b", out_l, out_dk_l, kw_l, e.d, e.k, e.kw);
                        end
                    end
                end else if (kw_l !== 1'b0) begin
                    failures++;
                    $display("FAIL lsb_kword_idle: got k_word=%b, required 0", kw_l);
                end
            end
        end
    end

    // Drive one bit at a negedge; returns at the negedge after it was sampled.
    task automatic send_bit(input logic d, input logic k, input bit lsb);
        if (lsb) begin
            data_l = d; dk_l = k; data_m = 1'b0; dk_m = 1'b0;
        end else begin
            data_m = d; dk_m = k; data_l = 1'b0; dk_l = 1'b0;
        end
        @(negedge clk);
    endtask

    // Send serial positions first..first+n-1 of a word in the lane's bit order.
    task automatic send_word(input logic [7:0] w, input logic [7:0] k, input bit lsb,
                             input int first, input int n);
        int idx;
        for (int i = first; i < first + n; i++) begin
            idx = lsb ? i : (BITS - 1 - i);
            send_bit(w[idx], k[idx], lsb);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        data_m = 1'b0; dk_m = 1'b0; data_l = 1'b0; dk_l = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_bit(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({out_m, out_dk_m, valid_m, kw_m, locked_m} !== 19'd0) begin
            failures++;
            $display("FAIL reset_msb: got out=%h out_DK=%h v=%b k=%b l=%b, required all 0", out_m, out_dk_m, valid_m, kw_m, locked_m);
        end
        checks++;
        if ({out_l, out_dk_l, valid_l, kw_l, locked_l} !== 19'd0) begin
            failures++;
            $display("FAIL reset_lsb: got out=%h out_DK=%h v=%b k=%b l=%b, required all 0", out_l, out_dk_l, valid_l, kw_l, locked_l);
        end
    endtask

    task automatic test_lock();
        apply_reset();
        q_m.push_back('{d: COMMA, k: 8'hFF, kw: 1'b1});
        send_word(COMMA, 8'hFF, 1'b0, 0, 7);
        check_bit("lock_early_locked", locked_m, 1'b0);
        check_bit("lock_early_valid", valid_m, 1'b0);
        send_word(COMMA, 8'hFF, 1'b0, 7, 1);
        check_bit("lock_locked", locked_m, 1'b1);
        check_bit("lock_valid", valid_m, 1'b1);
        t_lock = cyc;
    endtask

    task automatic test_data_word();
        q_m.push_back('{d: 8'h5A, k: 8'h00, kw: 1'b0});
        send_word(8'h5A, 8'h00, 1'b0, 0, 1);
        check_bit("valid_one_cycle", valid_m, 1'b0);
        send_word(8'h5A, 8'h00, 1'b0, 1, 7);
        check_bit("data_valid", valid_m, 1'b1);
        checks++;
        if (cyc - t_lock != BITS) begin
            failures++;
            $display("FAIL word_spacing: got %0d cycles, required %0d", cyc - t_lock, BITS);
        end
    endtask

    task automatic test_hunt_dk0();
        apply_reset();
        for (int i = 0; i < BITS; i++) begin
            send_bit(COMMA[BITS-1-i], 1'b0, 1'b0);
            checks++;
            if (valid_m !== 1'b0 || locked_m !== 1'b0) begin
                failures++;
                $display("FAIL hunt_dk0: got valid=%b locked=%b, required 0/0", valid_m, locked_m);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [7:0] c;
        c = COMMA;
        apply_reset();
        q_m.push_back('{d: COMMA, k: 8'hFF, kw: 1'b1});
        send_word(COMMA, 8'hFF, 1'b0, 0, 8);
        check_bit("mis_initial_lock", locked_m, 1'b1);
        // Boundary words straddle filler/comma and comma/comma.
        q_m.push_back('{d: {3'b000, c[7:3]}, k: 8'h1F, kw: 1'b0});
        q_m.push_back('{d: {c[2:0], c[7:3]}, k: 8'hFF, kw: 1'b1});
        q_m.push_back('{d: {c[2:0], c[7:3]}, k: 8'hFF, kw: 1'b1});
        send_word(8'h00, 8'h00, 1'b0, 0, 3);
        send_word(COMMA, 8'hFF, 1'b0, 0, 8);
        send_word(COMMA, 8'hFF, 1'b0, 0, 8);
        send_word(COMMA, 8'hFF, 1'b0, 0, 7);
        check_bit("mis_two_misses_locked", locked_m, 1'b1);
        send_word(COMMA, 8'hFF, 1'b0, 7, 1);
        check_bit("mis_drop_locked", locked_m, 1'b0);
        check_bit("mis_drop_valid", valid_m, 1'b0);
        q_m.push_back('{d: COMMA, k: 8'hFF, kw: 1'b1});
        send_word(COMMA, 8'hFF, 1'b0, 0, 7);
        check_bit("relock_early", locked_m, 1'b0);
        send_word(COMMA, 8'hFF, 1'b0, 7, 1);
        check_bit("relock_locked", locked_m, 1'b1);
        check_bit("relock_valid", valid_m, 1'b1);
    endtask

    task automatic test_reset_mid();
        send_word(8'h5A, 8'h00, 1'b0, 0, 4);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_m, out_dk_m, valid_m, kw_m, locked_m} !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid: got out=%h out_DK=%h v=%b k=%b l=%b, required all 0", out_m, out_dk_m, valid_m, kw_m, locked_m);
        end
        checks++;
        if (dut.state_q !== HUNT) begin
            failures++;
            $display("FAIL reset_mid_state: got %b, required HUNT", dut.state_q);
        end
        @(negedge clk);
        reset = 1'b0;
        q_m.push_back('{d: COMMA, k: 8'hFF, kw: 1'b1});
        send_word(COMMA, 8'hFF, 1'b0, 0, 7);
        check_bit("post_reset_no_partial", valid_m, 1'b0);
        send_word(COMMA, 8'hFF, 1'b0, 7, 1);
        check_bit("post_reset_lock", locked_m, 1'b1);
    endtask

    task automatic test_lsb_first();
        apply_reset();
        q_l.push_back('{d: COMMA, k: 8'hFF, kw: 1'b1});
        q_l.push_back('{d: 8'h3C, k: 8'h00, kw: 1'b0});
        send_word(COMMA, 8'hFF, 1'b1, 0, 8);
        check_bit("lsb_locked", locked_l, 1'b1);
        check_bit("lsb_msb_idle", locked_m, 1'b0);
        send_word(8'h3C, 8'h00, 1'b1, 0, 8);
        check_bit("lsb_data_valid", valid_l, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        #1;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_lock();
        test_data_word();
        test_hunt_dk0();
        test_misaligned();
        test_reset_mid();
        test_lsb_first();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (q_m.size() != 0 || q_l.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d/%0d words pending, required 0/0", q_m.size(), q_l.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deser_align.md
DESER_ALIGN -- requirements
Module: deser_align

Interface
REQ-001 SHALL have parameter BITS, 8, parallel word width (BITS >= 2).
REQ-002 SHALL have parameter COMMA, 8'hBC (BITS wide), alignment K-character pattern.
REQ-003 SHALL have parameter LOSS, 3, count of consecutive misaligned commas that drops lock (LOSS >= 1).
REQ-004 SHALL have parameter MSB_FIRST, 1; 1 = first serial bit lands in out[BITS-1], 0 = first bit lands in out[0].
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port data, input, 1, serial data bit, sampled every clk edge.
REQ-008 SHALL have port DK, input, 1, serial control-flag bit, sampled with data.
REQ-009 SHALL have port out, output, BITS, aligned parallel data word.
REQ-010 SHALL have port out_DK, output, BITS, per-bit control flags of that word.
REQ-011 SHALL have port valid, output, 1, one-cycle strobe marking a new word on out/out_DK.
REQ-012 SHALL have port k_word, output, 1, high with valid when out_DK is all ones.
REQ-013 SHALL have port locked, output, 1, high while in LOCKED state.

Function
REQ-014 SHALL shift data into data_sr and DK into dk_sr every edge: MSB_FIRST=1 -> {sr[BITS-2:0], bit}; MSB_FIRST=0 -> {bit, sr[BITS-1:1]}.
REQ-015 SHALL evaluate match on the shift-next values: next data_sr == COMMA and next dk_sr all ones.
REQ-016 SHALL implement states HUNT and LOCKED with a bit counter bit_cnt (0..BITS-1) and a miss counter miss_cnt (0..LOSS).
REQ-017 In HUNT, match at an edge SHALL register out/out_DK from the shift-next values, assert valid and k_word, enter LOCKED, clear bit_cnt and miss_cnt.
REQ-018 In HUNT without match, valid SHALL stay 0 and out/out_DK SHALL hold.
REQ-019 In LOCKED, bit_cnt SHALL increment every edge and wrap from BITS-1 to 0; the wrap edge SHALL register the word and pulse valid for exactly one cycle.
REQ-020 Latency: valid SHALL be high in the cycle immediately after the edge sampling the word's last bit; words SHALL appear every BITS cycles.
REQ-021 Match on a wrap edge (aligned comma) SHALL be a normal word with k_word=1 and SHALL clear miss_cnt.
REQ-022 Match on a non-wrap edge (misaligned comma) SHALL increment miss_cnt, produce no valid, and SHALL not disturb bit_cnt.
REQ-023 When miss_cnt reaches LOSS, the FSM SHALL enter HUNT at that edge, deassert locked, and clear both counters; re-acquisition follows REQ-017 from the next edge.
REQ-024 Data word equal to COMMA with any DK bit 0 SHALL not match.
REQ-025 k_word SHALL be 0 whenever valid is 0.

Reset
REQ-026 reset high SHALL immediately force HUNT, data_sr=0, dk_sr=0, bit_cnt=0, miss_cnt=0, out=0, out_DK=0, valid=0, k_word=0, locked=0, including mid-word.
REQ-027 After reset release, the first sampling edge SHALL be the first edge with reset low; no partial word from before reset SHALL be emitted.

Structure
REQ-028 State encoding (HUNT=0, LOCKED=1) and default COMMA SHALL live in shared package deser_pkg.
REQ-029 The dual shift register (data_sr, dk_sr, MSB_FIRST steering, shift-next outputs) SHALL be sub-module deser_shift; FSM and counters stay in deser_align.

Verification (BITS=8, COMMA=8'hBC, LOSS=3, MSB_FIRST=1 unless stated)
REQ-030 Reset, serial 10111100 with DK=1 all bits -> after 8th bit edge: locked=1, valid one cycle, out=BC, out_DK=FF, k_word=1.
REQ-031 Locked, then 0x5A with DK=0 -> valid exactly 8 cycles after previous valid, out=5A, out_DK=00, k_word=0.
REQ-032 Serial 0xBC with DK=0 in HUNT -> locked stays 0, valid never asserts.
REQ-033 Locked, three commas each shifted 3 bits off boundary -> locked drops at third comma's last bit edge, no valid for them; next comma -> relock, out=BC.
REQ-034 reset pulsed after 4 bits of a locked word -> all outputs 0 without a clock edge, state HUNT.
REQ-035 MSB_FIRST=0, lock with LSB-first comma then LSB-first 0x3C (DK=0) -> out=3C, out_DK=00.
